// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared definitions for the buffered UART transmitter
//
// Register offsets, STATUS bit positions, serialiser state encoding and the
// divider floor used by uart_tx_fifo and its FIFO.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).

package uart_pkg;

  // Byte offsets inside the UART window
  localparam logic [3:0] REG_DATA   = 4'h0;
  localparam logic [3:0] REG_DIV    = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;

  // STATUS bit positions
  localparam int STAT_EMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_BUSY_BIT   = 2;
  localparam int STAT_PARITY_BIT = 3;
  localparam int STAT_LEVEL_LSB  = 8;

  // Smallest clocks-per-bit the serialiser can run with
  localparam logic [31:0] MIN_DIV = 32'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , S_PARITY = 3'd4
`endif
  } tx_state_e;

  // Divider writes below the floor are stored as the floor
  function automatic logic [31:0] clamp_div(input logic [31:0] value);
    return (value < MIN_DIV) ? MIN_DIV : value;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - synchronous byte FIFO with registered full/empty flags
//
// Ports:
//   clk_i, reset_i       clock, synchronous active-high reset
//   push_i, data_i       write request and byte; ignored while full_o is high
//   pop_i, data_o        read request and head byte (valid while !empty_o)
//   full_o, empty_o      registered flags, updated the cycle after a push/pop
//   level_o              number of stored bytes, 0..DEPTH

module byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [7:0]               data_i,
  input  logic                     pop_i,
  output logic [7:0]               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  // Flags are registered, so a slot freed by a pop is only usable one
  // cycle later; this keeps the write-accept path short.
  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  always_comb begin
    level_d = level_q;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
      empty_q <= (level_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered memory-mapped UART transmitter (8N1)
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb   native bus request (wstrb==0 means read)
//   mem_ready, mem_rdata  combinational accept and read data
//   ser_tx                serial line, idle high
//   tx_busy               FIFO non-empty or frame in flight
// Registers: 0x0 DATA (push), 0x4 DIV, 0x8 STATUS, 0xC reserved.
// Optional feature macro: UART_TX_PARITY_EN (even parity bit, STATUS bit3).

module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] DEFAULT_DIV = 32'd868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ser_tx,
  output logic        tx_busy
);

  localparam int LW = $clog2(DEPTH) + 1;

  // Bus decode
  logic          is_write;
  logic          sel_data;
  logic          sel_div;
  logic          sel_status;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [LW-1:0] fifo_level;
  logic [31:0]   status_w;

  // Registers
  logic [31:0] div_q;
  tx_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] div_lat_q, div_lat_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        ser_tx_q, ser_tx_d;
  logic        load_frame;
`ifdef UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign is_write   = |mem_wstrb;
  assign sel_data   = (mem_addr == REG_DATA);
  assign sel_div    = (mem_addr == REG_DIV);
  assign sel_status = (mem_addr == REG_STATUS);

  // Only a DATA write against a full FIFO waits; everything else completes
  // in the request cycle.
  assign mem_ready = mem_valid & ~(is_write & sel_data & fifo_full);
  assign fifo_push = mem_valid & mem_ready & is_write & sel_data & mem_wstrb[0];

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (fifo_push),
    .data_i  (mem_wdata[7:0]),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= DEFAULT_DIV;
    end else if (mem_valid && is_write && sel_div) begin
      div_q <= clamp_div(mem_wdata);
    end
  end

  assign tx_busy = ~fifo_empty | (state_q != S_IDLE);

  always_comb begin
    status_w                              = '0;
    status_w[STAT_EMPTY_BIT]              = fifo_empty;
    status_w[STAT_FULL_BIT]               = fifo_full;
    status_w[STAT_BUSY_BIT]               = tx_busy;
`ifdef UART_TX_PARITY_EN
    status_w[STAT_PARITY_BIT]             = 1'b1;
`else
    status_w[STAT_PARITY_BIT]             = 1'b0;
`endif
    status_w[STAT_LEVEL_LSB +: 8]         = 8'(fifo_level);
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_valid && !is_write) begin
      if (sel_div)         mem_rdata = div_q;
      else if (sel_status) mem_rdata = status_w;
    end
  end

  // Serialiser: one bit period is div_lat_q cycles, counted down to zero.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_lat_d  = div_lat_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    load_frame = 1'b0;
    fifo_pop   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) load_frame = 1'b1;
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d   = S_DATA;
          cnt_d     = div_lat_q - 32'd1;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = div_lat_q - 32'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          cnt_d   = div_lat_q - 32'd1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == '0) begin
          // Chain straight into the next start bit when more data waits
          if (!fifo_empty) load_frame = 1'b1;
          else             state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Frame start: pop the head and latch DIV so later writes only affect
    // the following frame.
    if (load_frame) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_head;
      div_lat_d = div_q;
      cnt_d     = div_q - 32'd1;
      state_d   = S_START;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^fifo_head;
`endif
    end

    // Output is registered from the next state so the line level changes
    // on the same edge as the state.
    case (state_d)
      S_START:  ser_tx_d = 1'b0;
      S_DATA:   ser_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: ser_tx_d = parity_d;
`endif
      default:  ser_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      div_lat_q <= DEFAULT_DIV;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ser_tx_q  <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_lat_q <= div_lat_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ser_tx_q  <= ser_tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign ser_tx = ser_tx_q;

endmodule
